// File: rtl/pe_arr_seq.sv
// pe_arr_seq: runs one systolic-array job (clear, skewed operand feed, drain, capture); result valid 1+k_len+1+ROWS+COLS+1 cycles after the first busy cycle.
// Result is held on res_valid_o until res_ready_i; define PE_ARR_SEQ_PERF_EN to add the perf_cycles_o busy-cycle counter.
module pe_arr_seq #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int AW   = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [AW:0]             k_len_i,
    input  logic                    abort_i,
    output logic                    busy_o,
    output logic                    w_rd_en_o,
    output logic [AW-1:0]           w_rd_addr_o,
    input  logic [8*ROWS-1:0]       w_rd_data_i,
    output logic                    a_rd_en_o,
    output logic [AW-1:0]           a_rd_addr_o,
    input  logic [8*COLS-1:0]       a_rd_data_i,
    output logic                    arr_clr_o,
    output logic                    arr_fire_o,
    output logic [8*ROWS-1:0]       arr_in_w_o,
    output logic [8*COLS-1:0]       arr_in_a_o,
    input  logic [32*ROWS*COLS-1:0] arr_outs_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [32*ROWS*COLS-1:0] res_data_o
`ifdef PE_ARR_SEQ_PERF_EN
    ,
    output logic [31:0]             perf_cycles_o
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DONE} state_t;

    // FLUSH spans the read-return cycle plus ROWS+COLS+1 drain cycles.
    localparam logic [AW:0] FLUSH_LAST = (AW+1)'(ROWS + COLS + 1);

    state_t                    state_q, state_d;
    logic [AW:0]               k_len_q, k_len_d;
    logic [AW:0]               cnt_q, cnt_d;
    logic                      res_valid_q, res_valid_d;
    logic [32*ROWS*COLS-1:0]   res_data_q, res_data_d;
    logic                      rvld_q, fire_q;
    logic                      rd_en, flush_pipe;

    assign flush_pipe = abort_i && (state_q != S_IDLE);
    assign rd_en      = (state_q == S_FEED);

    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_CLEAR;
                    k_len_d = k_len_i;
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = (k_len_q == '0) ? S_FLUSH : S_FEED;
            end
            S_FEED: begin
                if (cnt_q == k_len_q - 1'b1) begin
                    cnt_d   = '0;
                    state_d = S_FLUSH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    state_d     = S_DONE;
                    res_valid_d = 1'b1;
                    res_data_d  = arr_outs_i;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (res_ready_i) begin
                    state_d     = S_IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort beats a same-cycle handshake; the result is simply dropped.
        if (flush_pipe) begin
            state_d     = S_IDLE;
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            k_len_q     <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    // rvld_q marks read data on the buffer buses; fire_q follows the lane-0 register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvld_q <= 1'b0;
            fire_q <= 1'b0;
        end else if (flush_pipe) begin
            rvld_q <= 1'b0;
            fire_q <= 1'b0;
        end else begin
            rvld_q <= rd_en;
            fire_q <= rvld_q;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_w_lane
        logic [r:0][7:0] dly_q;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                dly_q <= '0;
            end else if (flush_pipe) begin
                dly_q <= '0;
            end else begin
                dly_q[0] <= rvld_q ? w_rd_data_i[8*r +: 8] : 8'd0;
                for (int d = 1; d <= r; d++) dly_q[d] <= dly_q[d-1];
            end
        end
        assign arr_in_w_o[8*r +: 8] = dly_q[r];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_a_lane
        logic [c:0][7:0] dly_q;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                dly_q <= '0;
            end else if (flush_pipe) begin
                dly_q <= '0;
            end else begin
                dly_q[0] <= rvld_q ? a_rd_data_i[8*c +: 8] : 8'd0;
                for (int d = 1; d <= c; d++) dly_q[d] <= dly_q[d-1];
            end
        end
        assign arr_in_a_o[8*c +: 8] = dly_q[c];
    end

    assign busy_o      = (state_q != S_IDLE);
    assign arr_clr_o   = (state_q == S_CLEAR);
    assign w_rd_en_o   = rd_en;
    assign a_rd_en_o   = rd_en;
    assign w_rd_addr_o = rd_en ? cnt_q[AW-1:0] : '0;
    assign a_rd_addr_o = rd_en ? cnt_q[AW-1:0] : '0;
    assign arr_fire_o  = fire_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;

`ifdef PE_ARR_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == S_IDLE) begin
            if (start_i) perf_d = '0;
        end else if (perf_q != 32'hFFFF_FFFF) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign perf_cycles_o = perf_q;
`endif

endmodule

// File: doc/pe_arr_seq.md
# pe_arr_seq

Sequencer for the systolic `PE_ARR` datapath. It accepts a job of `k_len` inner-product steps and reads weight and activation vectors from two single-port operand buffers. It skews each lane onto the array edge inputs, drives the array fire and clear controls, waits for the wavefront to drain, then captures the full `outs_port` vector. The captured result is presented on a valid/ready interface. It sits between the operand buffers and the array, one instance per array.

## Interface
- `ROWS`, 4: array rows; the width of the weight vector is `8*ROWS`.
- `COLS`, 4: array columns; the width of the activation vector is `8*COLS`.
- `AW`, 8: operand buffer address width; `k_len` maximum is `2**AW`.
- `clk` in 1: the single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle job request; sampled only in IDLE.
- `k_len` in AW+1: number of steps; sampled together with `start`.
- `abort` in 1: cancels the current job from any state.
- `busy` out 1: high in every state except IDLE.
- `w_rd_en` out 1: weight buffer read strobe.
- `w_rd_addr` out AW: weight buffer address.
- `w_rd_data` in 8*ROWS: weight vector; returned one cycle after `w_rd_en`.
- `a_rd_en` out 1: activation buffer read strobe.
- `a_rd_addr` out AW: activation buffer address.
- `a_rd_data` in 8*COLS: activation vector; returned one cycle after `a_rd_en`.
- `arr_clr` out 1: active-high one-cycle accumulator clear; top level inverts it into the array `rstn`.
- `arr_fire` out 1: drives the array `fire` input.
- `arr_in_w` out 8*ROWS: skewed weights to the array.
- `arr_in_a` out 8*COLS: skewed activations to the array.
- `arr_outs` in 32*ROWS*COLS: the array `outs_port`.
- `res_valid` out 1: captured result is available.
- `res_ready` in 1: result consumer accepts the result.
- `res_data` out 32*ROWS*COLS: registered snapshot of `arr_outs`.

## Operation
- **States:** IDLE, CLEAR, FEED, FLUSH, DONE.
- **IDLE → CLEAR:** on `start`.
  - `k_len` is latched.
  - `arr_clr` is high for the single CLEAR cycle.
- **CLEAR → FEED:** when `k_len != 0`.
- **CLEAR → FLUSH:** when `k_len == 0`, so the result is all zeros.
- **FEED:** lasts `k_len` cycles.
  - `w_rd_en = a_rd_en = 1`.
  - Both addresses count 0 .. `k_len-1`.
- **Skew:** returned data is registered, then weight lane r is delayed by r extra cycles and activation lane c by c extra cycles.
  - Implemented as shift-register delay lines.
  - Lane 0 has no extra delay.
  - Delay lines shift zeros whenever no data is returned.
- **Fire:** `arr_fire` is high for exactly `k_len` cycles, aligned with lane-0 data reaching the array.
- **FLUSH:** fixed count of `ROWS+COLS+1` cycles after the last read returns.
  - Covers the skew depth plus the PE-to-PE register hops.
  - Read strobes are low during FLUSH.
- **FLUSH → DONE:** at the end of FLUSH, `res_data <= arr_outs` and `res_valid` is set.
- **DONE → IDLE:** `res_valid` and `res_data` are held stable until `res_valid & res_ready`.
  - `res_valid` falls on the cycle after the handshake.
- **`start` while busy:** ignored; no queueing.
- **Abort:** `abort` in any non-IDLE state forces IDLE on the next edge.
  - Clears `res_valid`, `arr_fire`, the read strobes and all delay lines.
  - The array accumulators are left as-is; the next job's CLEAR resets them.
- **Abort and handshake in the same DONE cycle:** abort wins; the result counts as consumed.
- **Overflow:** accumulation overflow is the array's concern; the sequencer does no arithmetic on data.

## Timing
- **Reset values:** state IDLE, every output 0.
  - Includes `busy`, `arr_clr`, `arr_fire`, both strobes, both addresses, `arr_in_w`, `arr_in_a`, `res_valid` and `res_data`.
- **Start handling:** `start` sampled at edge t gives `busy` = 1 and `arr_clr` = 1 in cycle t+1, and FEED from t+2.
- **First array input:** first `arr_in_w` / `arr_in_a` lane-0 value appears 2 cycles after the first read strobe, with `arr_fire` high in that same cycle.
- **Start-to-valid latency:** `1 + k_len + 1 + ROWS+COLS+1` cycles from the first busy cycle to `res_valid`.
  - At k_len = 0, FLUSH follows CLEAR directly.
- **Throughput:** minimum job-to-job gap is 1 IDLE cycle after the handshake.

## Configuration
- **`PE_ARR_SEQ_PERF_EN` defined:** adds output `perf_cycles`, 32 bits.
  - The counter increments on every busy cycle and is cleared on `start` acceptance.
  - It freezes in IDLE and saturates at `32'hFFFF_FFFF`.
  - Reset value is 0.
- **Macro undefined:** the port and the counter do not exist, and the rest of the behaviour is identical.

## Test plan
- **Basic 2x2 job:** ROWS = COLS = 2, `k_len` = 3, weights rows {1,2},{3,4},{5,6}, activations {1,1},{2,2},{3,3}.
  - `res_valid` rises after 1+3+1+5 = 10 busy cycles.
  - `res_data` equals the array reference model.
- **Zero-length job:** `k_len` = 0 → no read strobes, `arr_fire` never high, `res_data` all zero, `res_valid` after 7 busy cycles.
- **Backpressure:** `res_ready` held low 20 cycles in DONE.
  - `res_data` and `res_valid` stay stable.
  - A `start` pulse during the wait is ignored.
  - Release `res_ready` → IDLE next cycle.
- **Abort mid-FEED:** `k_len` = 8, assert `abort` at FEED cycle 4.
  - Next cycle: `busy` = 0, strobes 0, `arr_fire` 0.
  - A following job with `k_len` = 2 produces the correct result, proving CLEAR works.
- **Async reset:** assert `rst` mid-FLUSH, off-edge → all outputs 0 immediately, state IDLE.
- **`PE_ARR_SEQ_PERF_EN`:** a `k_len` = 3 job on 2x2 → `perf_cycles` = 10 at `res_valid`, and more if `res_ready` is delayed, counting every DONE cycle.
